// File: rtl/t07_mmio_bridge.sv
// t07_mmio_bridge
// Bus-side stage behind the t07 memory handler. It takes the handler's
// level-held request (rwi_i/addr_i/wdata_i) and runs one Wishbone classic
// cycle per request. The falling edge of busy tells the handler that the
// transaction is complete. Fetch data lands in instr_o and load data lands
// in dataMMIO_o.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   rwi_i[1:0]        request code: 00 idle, 01 write, 10 read, 11 fetch
//   addr_i, wdata_i   request address and write data
//   busy              high while a bus transaction is in flight
//   dataMMIO_o        result of the last read
//   instr_o           result of the last fetch
//   timeout_o         one-cycle pulse when a transaction is aborted
//   wb_*              Wishbone classic-cycle master port
//
// Optional feature macro: T07_MMIO_TIMEOUT_EN
//   When this macro is defined, a transaction that is not acknowledged
//   within TIMEOUT_CYCLES bus cycles is aborted. A read or fetch that
//   times out returns ERR_WORD.
module t07_mmio_bridge #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_WORD       = 32'hBAD0_BAD0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  rwi_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy,
    output logic [31:0] dataMMIO_o,
    output logic [31:0] instr_o,
    output logic        timeout_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    localparam logic [1:0] RWI_WRITE = 2'b01;
    localparam logic [1:0] RWI_READ  = 2'b10;
    localparam logic [1:0] RWI_FETCH = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] req_rwi;

    // Every transfer uses the full 32-bit word. Narrower data has already
    // been sized upstream.
    assign wb_sel_o = 4'hF;

`ifdef T07_MMIO_TIMEOUT_EN
    // The abort fires on the last allowed BUS cycle. This gives exactly
    // TIMEOUT_CYCLES bus cycles before cyc/stb drop.
    localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    logic [15:0] wait_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ERR_WORD, 32'(TIMEOUT_CYCLES)};
    assign timeout_o  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_rwi    <= 2'b00;
            busy       <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= 32'h0;
            wb_dat_o   <= 32'h0;
            dataMMIO_o <= 32'h0;
            instr_o    <= 32'h0;
`ifdef T07_MMIO_TIMEOUT_EN
            timeout_o  <= 1'b0;
            wait_cnt   <= 16'h0;
`endif
        end else begin
`ifdef T07_MMIO_TIMEOUT_EN
            timeout_o <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (rwi_i != 2'b00) begin
                        // The bus registers double as the request latch.
                        // Inputs are not looked at again until IDLE.
                        req_rwi  <= rwi_i;
                        wb_adr_o <= addr_i;
                        wb_dat_o <= (rwi_i == RWI_WRITE) ? wdata_i : 32'h0;
                        wb_we_o  <= (rwi_i == RWI_WRITE);
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_BUS;
`ifdef T07_MMIO_TIMEOUT_EN
                        wait_cnt <= 16'h0;
`endif
                    end
                end
                S_BUS: begin
                    if (wb_ack_i) begin
                        if (req_rwi == RWI_READ)  dataMMIO_o <= wb_dat_i;
                        if (req_rwi == RWI_FETCH) instr_o    <= wb_dat_i;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end
`ifdef T07_MMIO_TIMEOUT_EN
                    // An ack that arrives on the limit cycle takes the branch above.
                    else if (wait_cnt == 16'(LIMIT)) begin
                        if (req_rwi == RWI_READ)  dataMMIO_o <= ERR_WORD;
                        if (req_rwi == RWI_FETCH) instr_o    <= ERR_WORD;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        busy      <= 1'b0;
                        timeout_o <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                S_DONE: begin
                    // This one dead cycle lets the handler see busy fall
                    // before a still-held request can re-issue.
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t07_mmio_bridge.sv
// Self-checking bench for t07_mmio_bridge.
// - A Wishbone slave model responds with programmable ack delays and
//   sometimes drives stray acks while the bus is idle.
// - The driver issues requests and pushes the expected bus transactions
//   into a queue.
// - A monitor pops the queue on each handshake and keeps a reference copy
//   of the result registers.
module tb_t07_mmio_bridge;

    localparam logic [31:0] ERR = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rwi_i = 2'b11;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        busy;
    logic [31:0] dataMMIO_o;
    logic [31:0] instr_o;
    logic        timeout_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;

    always #5 clk = ~clk;

    t07_mmio_bridge #(.TIMEOUT_CYCLES(4), .ERR_WORD(ERR)) dut (
        .clk(clk), .rst(rst), .rwi_i(rwi_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy(busy), .dataMMIO_o(dataMMIO_o), .instr_o(instr_o), .timeout_o(timeout_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver sample point: after the monitor (+2), well before the next posedge.
    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    typedef struct {
        logic [1:0]  rwi;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;
    txn_t q[$];

    // ---------------- Wishbone slave model ----------------
    int          force_delay = 0;
    logic [31:0] force_data = 32'h0;
    bit          stray_en = 1'b1;
    bit          stray_all = 1'b0;
    bit          in_txn = 1'b0;
    int          scnt = 0;

    always @(negedge clk) begin
        if (wb_cyc_o && wb_stb_o) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                scnt = force_delay;
            end
            if (scnt == 0) begin
                wb_ack_i = 1'b1;
                wb_dat_i = force_data;
            end else begin
                wb_ack_i = 1'b0;
                wb_dat_i = $urandom;
                scnt--;
            end
        end else begin
            in_txn = 1'b0;
            wb_ack_i = stray_all || (stray_en && ($urandom_range(0, 3) == 0));
            wb_dat_i = $urandom;
        end
    end

    // ---------------- Monitor / reference model ----------------
    logic [31:0] exp_dmmio = 32'h0;
    logic [31:0] exp_instr = 32'h0;
    bit   prev_cyc = 1'b0;
    bit   hs_prev = 1'b0;
    bit   hs, abort_now;
    txn_t mt;

    always begin
        @(negedge clk);
        #2;
        hs = 1'b0;
        abort_now = 1'b0;
        if (rst) begin
            exp_dmmio = 32'h0;
            exp_instr = 32'h0;
            q.delete();
        end else if (prev_cyc && !wb_cyc_o && !hs_prev) begin
            abort_now = 1'b1;
`ifdef T07_MMIO_TIMEOUT_EN
            if (q.size() > 0) begin
                mt = q.pop_front();
                if (mt.rwi == 2'b10) exp_dmmio = ERR;
                if (mt.rwi == 2'b11) exp_instr = ERR;
            end
`else
            checks++;
            failures++;
            $display("FAIL abort: bus cycle dropped without ack, adr %h", wb_adr_o);
`endif
        end
        check("sel", wb_sel_o, 4'hF);
        check("dataMMIO", dataMMIO_o, exp_dmmio);
        check("instr", instr_o, exp_instr);
`ifdef T07_MMIO_TIMEOUT_EN
        check("timeout_pulse", timeout_o, abort_now);
`else
        check("timeout_tied", timeout_o, 1'b0);
`endif
        if (!rst && wb_cyc_o && wb_stb_o && wb_ack_i) begin
            hs = 1'b1;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_txn: adr %h with no request pending", wb_adr_o);
            end else begin
                mt = q.pop_front();
                check("wb_adr", wb_adr_o, mt.addr);
                check("wb_we", wb_we_o, mt.rwi == 2'b01);
                check("wb_dat_o", wb_dat_o, (mt.rwi == 2'b01) ? mt.wdata : 32'h0);
                if (mt.rwi == 2'b10) exp_dmmio = wb_dat_i;
                if (mt.rwi == 2'b11) exp_instr = wb_dat_i;
            end
        end
        prev_cyc = wb_cyc_o;
        hs_prev = hs;
    end

    // ---------------- Driver ----------------
    bit in_done = 1'b0;

    task automatic do_txn(input logic [1:0] rwi, input logic [31:0] addr, input logic [31:0] wdata,
                          input int delay, input logic [31:0] data, input bit scramble, input int exp_hi);
        txn_t t;
        int lat;
        int hi;
        rwi_i = rwi;
        addr_i = addr;
        wdata_i = wdata;
        force_delay = delay;
        force_data = data;
        t.rwi = rwi;
        t.addr = addr;
        t.wdata = wdata;
        q.push_back(t);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!busy && lat < 6);
        check("req_to_busy", lat, in_done ? 2 : 1);
        if (!busy) begin
            in_done = 1'b0;
            return;
        end
        hi = 1;
        while (busy && hi < 400) begin
            if (scramble) begin
                addr_i = $urandom;
                wdata_i = $urandom;
                rwi_i = 2'($urandom_range(1, 3));
            end
            tick();
            if (busy) hi++;
        end
        if (hi >= 400) check("busy_stuck", busy, 1'b0);
        if (exp_hi > 0) check("busy_cycles", hi, exp_hi);
        in_done = 1'b1;
    endtask

    task automatic idle_gap(input int n);
        rwi_i = 2'b00;
        repeat (n) tick();
        in_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d;
        // Reset held with a fetch request pending
        repeat (2) begin
            tick();
            check("rst_busy", busy, 1'b0);
            check("rst_cyc", wb_cyc_o, 1'b0);
            check("rst_stb", wb_stb_o, 1'b0);
            check("rst_instr", instr_o, 32'h0);
            check("rst_adr", wb_adr_o, 32'h0);
        end
        rst = 1'b0;
        rwi_i = 2'b00;
        tick();
        check("post_rst_idle", busy, 1'b0);

        // Fetch with an ack in the third bus cycle, then a held re-issue
        do_txn(2'b11, 32'h0000_0040, 32'h0, 2, 32'h0010_0093, 1'b0, 3);
        check("fetch_instr", instr_o, 32'h0010_0093);
        do_txn(2'b11, 32'h0000_0040, 32'h0, 0, 32'h0020_0113, 1'b0, 1);
        check("fetch2_instr", instr_o, 32'h0020_0113);

        // Write leaves both result registers alone
        do_txn(2'b01, 32'h0000_1000, 32'h0000_00AB, 1, 32'h5555_5555, 1'b0, 2);
        check("write_instr_kept", instr_o, 32'h0020_0113);
        check("write_dmmio_kept", dataMMIO_o, 32'h0);

        // Read with the inputs scrambled during the bus phase
        do_txn(2'b10, 32'h0000_2000, 32'h0, 3, 32'hDEAD_BEEF, 1'b1, 4);
        check("read_dmmio", dataMMIO_o, 32'hDEAD_BEEF);

        // Reset in the second bus cycle, followed by late acks
        idle_gap(1);
        rwi_i = 2'b10;
        addr_i = 32'h0000_3000;
        wdata_i = 32'h0;
        force_delay = 6;
        force_data = 32'h1234_5678;
        q.push_back('{rwi: 2'b10, addr: 32'h0000_3000, wdata: 32'h0});
        n = 0;
        do begin
            tick();
            n++;
        end while (!busy && n < 4);
        check("rstmid_started", busy, 1'b1);
        tick();
        rst = 1'b1;
        rwi_i = 2'b00;
        tick();
        check("rstmid_cyc", wb_cyc_o, 1'b0);
        check("rstmid_stb", wb_stb_o, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_dmmio", dataMMIO_o, 32'h0);
        rst = 1'b0;
        stray_all = 1'b1;
        repeat (4) tick();
        check("late_ack_busy", busy, 1'b0);
        check("late_ack_dmmio", dataMMIO_o, 32'h0);
        stray_all = 1'b0;
        in_done = 1'b0;

`ifdef T07_MMIO_TIMEOUT_EN
        // Read with no ack: the bridge aborts after 4 bus cycles
        do_txn(2'b10, 32'h0000_4000, 32'h0, 1000, 32'h0, 1'b0, 4);
        check("timeout_dmmio", dataMMIO_o, ERR);
        idle_gap(1);
`endif

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            d = $urandom_range(0, 3);
            do_txn(2'($urandom_range(1, 3)), $urandom, $urandom, d, $urandom,
                   ($urandom_range(0, 3) == 0), d + 1);
            if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
        end

        idle_gap(3);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
